halt_ctrl: RTL and testbench

Parametrised run/halt controller for the core.
- Arms on a start pulse and latches the program end PC at that moment.
- Watches retired PCs and halts on program completion, on a programmable breakpoint, or on a cycle-budget timeout.
- Breakpoint stops are resumable; end and timeout stops are terminal until the next start.
- Sits beside the fetch stage; its halt output gates PC update and the register-file write enable.

---
 rtl/halt_ctrl_pkg.sv | 24 ++
 rtl/halt_ctrl_if.sv | 36 +++
 rtl/halt_ctrl_bp_match.sv | 34 +++
 rtl/halt_ctrl.sv | 121 ++++++++++++
 tb/tb_halt_ctrl.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/halt_ctrl_pkg.sv
// Shared types for the run/halt controller: FSM states, halt causes and
// the breakpoint-index width helper.
package halt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BREAK  = 2'd2,
    HALTED = 2'd3
  } halt_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_END     = 2'd1,
    CAUSE_BP      = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } halt_cause_e;

  // A single channel still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/halt_ctrl_if.sv
// Control/status bundle between the core (master) and halt_ctrl (slave).
interface halt_ctrl_if
  import halt_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int NUM_BP = 4,
  parameter int CYC_W  = 16
);
  localparam int IDX_W = idx_width(NUM_BP);

  logic                   start;
  logic [PC_W-1:0]        pc_end;
  logic [CYC_W-1:0]       max_cycles;
  logic [PC_W-1:0]        pc_curr;
  logic                   pc_valid;
  logic [NUM_BP*PC_W-1:0] bp_addr;
  logic [NUM_BP-1:0]      bp_en;
  logic                   resume;
  logic                   halt;
  logic                   running;
  logic [1:0]             halt_cause;
  logic [IDX_W-1:0]       bp_idx;
  logic [CYC_W-1:0]       cycle_count;
  logic                   done;

  modport master (
    output start, pc_end, max_cycles, pc_curr, pc_valid, bp_addr, bp_en, resume,
    input  halt, running, halt_cause, bp_idx, cycle_count, done
  );

  modport slave (
    input  start, pc_end, max_cycles, pc_curr, pc_valid, bp_addr, bp_en, resume,
    output halt, running, halt_cause, bp_idx, cycle_count, done
  );

endinterface

// File: rtl/halt_ctrl_bp_match.sv
// Breakpoint comparator bank with a lowest-index-wins priority encoder.
module bp_match
  import halt_pkg::*;
#(
  parameter int  PC_W   = 8,
  parameter int  NUM_BP = 4,
  localparam int IDX_W  = idx_width(NUM_BP)
) (
  input  logic [PC_W-1:0]        pc,
  input  logic [NUM_BP*PC_W-1:0] bp_addr,
  input  logic [NUM_BP-1:0]      bp_en,
  output logic                   any_hit,
  output logic [IDX_W-1:0]       hit_idx
);

  logic [NUM_BP-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_cmp
      assign hit[gi] = bp_en[gi] && (pc == bp_addr[gi*PC_W +: PC_W]);
    end
  endgenerate

  assign any_hit = |hit;

  // Scan downwards so the lowest matching channel is the last to write.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/halt_ctrl.sv
// Run/halt controller: arms on start, stops on end PC, breakpoint or cycle
// budget; breakpoint stops resume, end/timeout stops wait for a new start.
module halt_ctrl
  import halt_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int NUM_BP = 4,
  parameter int CYC_W  = 16
) (
  input logic        clk,
  input logic        rst_n,
  halt_ctrl_if.slave bus
);

  localparam int IDX_W = idx_width(NUM_BP);

  halt_state_e      state_reg, state_next;
  halt_cause_e      cause_reg, cause_next;
  logic [PC_W-1:0]  end_q;
  logic [CYC_W-1:0] budget_q;
  logic [CYC_W-1:0] cycle_count_reg;
  logic [IDX_W-1:0] bp_idx_reg;
  logic             skip_reg;
  logic             done_reg;

  logic             bp_any;
  logic [IDX_W-1:0] bp_hit_idx;
  logic             end_hit, bp_hit, timeout, arm;

  bp_match #(
    .PC_W   (PC_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .pc      (bus.pc_curr),
    .bp_addr (bus.bp_addr),
    .bp_en   (bus.bp_en & {NUM_BP{~skip_reg}}),
    .any_hit (bp_any),
    .hit_idx (bp_hit_idx)
  );

  assign end_hit = bus.pc_valid && (bus.pc_curr == end_q);
  assign bp_hit  = bus.pc_valid && bp_any;
  // Widened compare so an all-ones count cannot wrap into a false match.
  assign timeout = (budget_q != '0) &&
                   ((CYC_W+1)'(cycle_count_reg) + (CYC_W+1)'(1) == (CYC_W+1)'(budget_q));
  assign arm     = bus.start && (state_reg == IDLE || state_reg == HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    case (state_reg)
      IDLE, HALTED: begin
        if (bus.start) begin
          state_next = RUN;
          cause_next = CAUSE_NONE;
        end
      end
      RUN: begin
        if (end_hit) begin
          state_next = HALTED;
          cause_next = CAUSE_END;
        end else if (bp_hit) begin
          state_next = BREAK;
          cause_next = CAUSE_BP;
        end else if (timeout) begin
          state_next = HALTED;
          cause_next = CAUSE_TIMEOUT;
        end
      end
      BREAK: begin
        if (bus.resume) begin
          state_next = RUN;
          cause_next = CAUSE_NONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_reg       <= CAUSE_NONE;
      end_q           <= '0;
      budget_q        <= '0;
      cycle_count_reg <= '0;
      bp_idx_reg      <= '0;
      skip_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      cause_reg <= cause_next;
      done_reg  <= (state_next == HALTED) && (state_reg != HALTED);
      if (arm) begin
        end_q           <= bus.pc_end;
        budget_q        <= bus.max_cycles;
        cycle_count_reg <= '0;
        skip_reg        <= 1'b0;
      end else if (state_reg == RUN) begin
        if (cycle_count_reg != '1) cycle_count_reg <= cycle_count_reg + 1'b1;
        if (bus.pc_valid) skip_reg <= 1'b0;
        if (!end_hit && bp_hit) bp_idx_reg <= bp_hit_idx;
      end else if (state_reg == BREAK && bus.resume) begin
        skip_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.halt        = (state_reg != RUN);
    bus.running     = (state_reg == RUN);
    bus.halt_cause  = cause_reg;
    bus.bp_idx      = bp_idx_reg;
    bus.cycle_count = cycle_count_reg;
    bus.done        = done_reg;
  end

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed-vector bench for halt_ctrl with hand-computed expectations.
module tb_halt_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  halt_ctrl_if #(.PC_W(8), .NUM_BP(4), .CYC_W(16)) bus ();

  halt_ctrl #(.PC_W(8), .NUM_BP(4), .CYC_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [7:0] pc);
    bus.pc_curr  = pc;
    bus.pc_valid = 1'b1;
    tick();
    bus.pc_valid = 1'b0;
  endtask

  task automatic arm(input logic [7:0] pc_end, input logic [15:0] max_cycles);
    bus.pc_end     = pc_end;
    bus.max_cycles = max_cycles;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.pc_end     = '0;
    bus.max_cycles = '0;
    bus.pc_curr    = '0;
    bus.pc_valid   = 1'b0;
    bus.bp_addr    = '0;
    bus.bp_en      = '0;
    bus.resume     = 1'b0;

    // Reset values
    tick();
    tick();
    check("rst_halt", 32'(bus.halt), 32'd1);
    check("rst_running", 32'(bus.running), 32'd0);
    check("rst_cause", 32'(bus.halt_cause), 32'd0);
    check("rst_bp_idx", 32'(bus.bp_idx), 32'd0);
    check("rst_count", 32'(bus.cycle_count), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    tick();

    // Asynchronous reset mid-run
    arm(8'hFF, 16'd0);
    for (int i = 0; i < 5; i++) tick();
    check("run_count5", 32'(bus.cycle_count), 32'd5);
    check("run_running", 32'(bus.running), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_halt", 32'(bus.halt), 32'd1);
    check("arst_running", 32'(bus.running), 32'd0);
    check("arst_count", 32'(bus.cycle_count), 32'd0);
    check("arst_cause", 32'(bus.halt_cause), 32'd0);
    check("arst_done", 32'(bus.done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("arst_no_done", 32'(bus.done), 32'd0);

    // Normal completion at 0x10
    arm(8'h10, 16'd0);
    check("end_start_count", 32'(bus.cycle_count), 32'd0);
    for (int pc = 0; pc < 16; pc++) retire(8'(pc));
    check("end_pre_running", 32'(bus.running), 32'd1);
    retire(8'h10);
    check("end_halt", 32'(bus.halt), 32'd1);
    check("end_cause", 32'(bus.halt_cause), 32'd1);
    check("end_done", 32'(bus.done), 32'd1);
    check("end_count", 32'(bus.cycle_count), 32'd17);
    tick();
    check("end_done_pulse", 32'(bus.done), 32'd0);
    check("end_cause_hold", 32'(bus.halt_cause), 32'd1);

    // Breakpoint on channels 1 and 2 at 0x05, then resume
    bus.bp_addr = {8'h00, 8'h05, 8'h05, 8'h00};
    bus.bp_en   = 4'b0110;
    arm(8'h10, 16'd0);
    check("bp_arm_cause", 32'(bus.halt_cause), 32'd0);
    for (int pc = 0; pc < 6; pc++) retire(8'(pc));
    check("bp_halt", 32'(bus.halt), 32'd1);
    check("bp_running", 32'(bus.running), 32'd0);
    check("bp_cause", 32'(bus.halt_cause), 32'd2);
    check("bp_idx", 32'(bus.bp_idx), 32'd1);
    check("bp_done", 32'(bus.done), 32'd0);
    tick();
    tick();
    check("bp_count_frozen", 32'(bus.cycle_count), 32'd6);
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    check("bp_resume_running", 32'(bus.running), 32'd1);
    check("bp_resume_cause", 32'(bus.halt_cause), 32'd0);
    retire(8'h05);
    check("bp_no_retrap", 32'(bus.running), 32'd1);
    for (int pc = 6; pc < 17; pc++) retire(8'(pc));
    check("bp_end_cause", 32'(bus.halt_cause), 32'd1);
    check("bp_end_count", 32'(bus.cycle_count), 32'd18);

    // Timeout after 20 RUN cycles
    bus.bp_en = 4'b0000;
    arm(8'hFF, 16'd20);
    for (int i = 0; i < 19; i++) tick();
    check("to_pre_running", 32'(bus.running), 32'd1);
    tick();
    check("to_halt", 32'(bus.halt), 32'd1);
    check("to_cause", 32'(bus.halt_cause), 32'd3);
    check("to_count", 32'(bus.cycle_count), 32'd20);
    check("to_done", 32'(bus.done), 32'd1);

    // End, breakpoint and timeout on the same cycle: end wins
    bus.bp_addr = {8'h00, 8'h00, 8'h00, 8'h08};
    bus.bp_en   = 4'b0001;
    arm(8'h08, 16'd9);
    for (int pc = 0; pc < 9; pc++) retire(8'(pc));
    check("pri_end_cause", 32'(bus.halt_cause), 32'd1);
    check("pri_end_running", 32'(bus.running), 32'd0);
    check("pri_end_count", 32'(bus.cycle_count), 32'd9);

    // Breakpoint and timeout together: breakpoint wins
    bus.bp_addr = {8'h00, 8'h00, 8'h00, 8'h03};
    arm(8'hFF, 16'd4);
    for (int pc = 0; pc < 4; pc++) retire(8'(pc));
    check("pri_bp_cause", 32'(bus.halt_cause), 32'd2);
    check("pri_bp_idx", 32'(bus.bp_idx), 32'd0);

    // start in BREAK is ignored; start with resume resumes
    arm(8'h20, 16'd0);
    check("brk_start_ign", 32'(bus.running), 32'd0);
    check("brk_start_cause", 32'(bus.halt_cause), 32'd2);
    bus.start  = 1'b1;
    bus.resume = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.resume = 1'b0;
    check("brk_both_running", 32'(bus.running), 32'd1);
    check("brk_both_count", 32'(bus.cycle_count), 32'd4);

    // start during RUN does not relatch pc_end
    arm(8'h20, 16'd0);
    retire(8'h20);
    check("run_start_ign", 32'(bus.running), 32'd1);
    retire(8'hFF);
    check("run_orig_end", 32'(bus.halt_cause), 32'd1);

    // resume in HALTED does nothing; start re-arms
    bus.resume = 1'b1;
    tick();
    bus.resume = 1'b0;
    check("hlt_resume_running", 32'(bus.running), 32'd0);
    check("hlt_resume_cause", 32'(bus.halt_cause), 32'd1);
    bus.bp_en = 4'b0000;
    arm(8'h02, 16'd0);
    check("rearm_running", 32'(bus.running), 32'd1);
    check("rearm_count", 32'(bus.cycle_count), 32'd0);
    for (int pc = 0; pc < 3; pc++) retire(8'(pc));
    check("rearm_cause", 32'(bus.halt_cause), 32'd1);
    check("rearm_count_end", 32'(bus.cycle_count), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
